regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- General-purpose register file for the 5-stage MIPS32 pipeline: 32 x 32-bit registers.
- Serves as the responder for the decode stage's two read requests (enable + address → data).
- Accepts the single write-back from WB.
- Includes a post-reset clear sequencer, a busy flag, $0 hardwiring and same-cycle write-to-read bypass.

Parameters:
- DATA_W, 32, register width (matches RegBus)
- ADDR_W, 5, register address width (matches RegAddrBus)
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  synchronous reset, active-low
- we  input  1  write enable from WB
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- re1  input  1  read port 1 enable
- raddr1  input  ADDR_W  read port 1 address
- rdata1  output  DATA_W  read port 1 data, combinational
- re2  input  1  read port 2 enable
- raddr2  input  ADDR_W  read port 2 address
- rdata2  output  DATA_W  read port 2 data, combinational
- busy  output  1  clear sequence in progress; pipeline must stall while high

Behaviour:
- Reset (already decided): one clock clk; reset rst is synchronous and active-low. rst is sampled only at the rising edge of clk.
- States: RESET, CLEAR, READY. busy=1 in RESET and CLEAR, 0 in READY.
- rst low at a posedge: state→RESET, clr_ptr→1. No array write.
- RESET with rst high at a posedge: state→CLEAR.
- CLEAR, each posedge with rst high:
  - reg[clr_ptr]←0, clr_ptr←clr_ptr+1.
  - After clearing entry 31 (clr_ptr==31): state→READY. No wrap to 0.
- Timing: with rst released, busy falls after exactly 32 rising edges (1 RESET exit + 31 clears).
- rst low at any point, including mid-CLEAR or in READY: state→RESET next edge; sequence restarts from entry 1. Any write on that edge is discarded.
- Write: reg[waddr]←wdata at posedge iff all hold:
  - state==READY
  - rst high
  - we=1
  - waddr!=0
- Writes while busy are dropped silently; no queuing.
- reg[0] is never written; it reads as 0 always.
- Read port n is combinational, priority order:
  1. rst low or busy → 0
  2. ren=0 → 0
  3. raddrn==0 → 0
  4. we=1 and waddr==raddrn → wdata (bypass, same cycle)
  5. otherwise → reg[raddrn]
- Both ports are independent. Both may read the same address simultaneously; both may bypass in the same cycle.
- Output reset values: rdata1=0, rdata2=0, busy=1.
- Read latency: 0 cycles. Write-to-read latency: 0 cycles via bypass, otherwise visible after the write edge.
- No X propagation: the array is fully cleared before busy deasserts.

Optional Feature:
- Macro: REGFILE_DBG_PORT_EN.
- Defined: adds ports dbg_addr input ADDR_W and dbg_data output DATA_W.
  - dbg_data = reg[dbg_addr] combinationally, raw array contents.
  - No bypass, no enable gating; dbg_addr==0 → 0.
  - Returns 0 while busy or rst low.
  - For testbench/trace use only; no effect on other ports.
- Undefined: both ports absent; no added logic.

Test Plan:
- Reset clear: rst low 3 cycles, then high → busy=1 for exactly 32 posedges, then 0. Afterwards, reads of r1..r31 with re=1 → 0x00000000.
- Write then read: we=1, waddr=5, wdata=0x12345678 at edge k; cycle k+1: re1=1, raddr1=5 → rdata1=0x12345678. Same read with re1=0 → 0.
- Same-cycle bypass: we=1, waddr=7, wdata=0xDEADBEEF, re2=1, raddr2=7, re1=1, raddr1=7 in one cycle → rdata1=rdata2=0xDEADBEEF before the edge. Next cycle, we=0 → still 0xDEADBEEF from the array.
- $0 hardwiring: we=1, waddr=0, wdata=0xFFFFFFFF; same cycle and next cycle: re1=1, raddr1=0 → 0x00000000. With REGFILE_DBG_PORT_EN defined, dbg_addr=0 → 0.
- Reset mid-operation: write r9=0xA5A5A5A5; pulse rst low 1 cycle during READY → busy rises next edge. During CLEAR, we=1, waddr=10, wdata=0x1 → dropped. After busy falls: r9 → 0, r10 → 0.
- Reset during CLEAR: assert rst after 10 clear edges, release → busy stays high a full 32 edges from release; all registers → 0.

Source files
------------

// File: rtl/regfile_2r1w.sv
// 32x32 two-read, one-write register file with post-reset clear sequencer and write bypass.
// Optional debug read port enabled by defining REGFILE_DBG_PORT_EN.
module regfile_2r1w #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32  // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy
`ifdef REGFILE_DBG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    localparam logic [1:0] StReset = 2'd0;
    localparam logic [1:0] StClear = 2'd1;
    localparam logic [1:0] StReady = 2'd2;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_val;

    // Entry 0 has no storage; it always reads as zero.
    logic [DATA_W-1:0] mem_q [1:NUM_REGS-1];

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_en     = 1'b0;
        wr_idx    = waddr;
        wr_val    = wdata;
        case (state_q)
            StReset: state_d = StClear;
            StClear: begin
                wr_en  = rst;
                wr_idx = clr_ptr_q;
                wr_val = '0;
                if (clr_ptr_q == LastIdx) begin
                    state_d = StReady;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            StReady: wr_en = rst && we && (waddr != '0);
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StReset;
            clr_ptr_q <= ADDR_W'(1);
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_val;
        end
    end

    assign busy = (state_q != StReady);

    assign rdata1 = (!rst || busy || !re1 || (raddr1 == '0)) ? '0 :
                    (we && (waddr == raddr1))                ? wdata :
                                                               mem_q[raddr1];

    assign rdata2 = (!rst || busy || !re2 || (raddr2 == '0)) ? '0 :
                    (we && (waddr == raddr2))                ? wdata :
                                                               mem_q[raddr2];

`ifdef REGFILE_DBG_PORT_EN
    // Raw array view: no bypass, no enable gating.
    assign dbg_data = (!rst || busy || (dbg_addr == '0)) ? '0 : mem_q[dbg_addr];
`else
    // Debug port absent.
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed vector table, reset/clear sequences,
// and randomized traffic against an array-based reference model.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        busy;
`ifdef REGFILE_DBG_PORT_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus rising edges seen since rst was released.
    logic [31:0] mdl [32];
    int          rel_edges = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .NUM_REGS(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re1     (re1),
        .raddr1  (raddr1),
        .rdata1  (rdata1),
        .re2     (re2),
        .raddr2  (raddr2),
        .rdata2  (rdata2),
        .busy    (busy)
`ifdef REGFILE_DBG_PORT_EN
        ,
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
`endif
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic ren, input logic [4:0] ra);
        if (!rst || rel_edges < 32 || !ren || ra == 5'd0) return 32'h0;
        if (we && waddr == ra) return wdata;
        return mdl[ra];
    endfunction

    // One rising edge; the model applies the same inputs the DUT samples.
    task automatic edge_update();
        @(posedge clk);
        if (!rst) begin
            rel_edges = 0;
        end else if (rel_edges < 32) begin
            rel_edges++;
            if (rel_edges == 32) begin
                for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
            end
        end else if (we && waddr != 5'd0) begin
            mdl[waddr] = wdata;
        end
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic check_model(input string name);
        check({name, "_rd1"}, rdata1, exp_read(re1, raddr1));
        check({name, "_rd2"}, rdata2, exp_read(re2, raddr2));
        check({name, "_busy"}, {31'b0, busy}, {31'b0, (rel_edges < 32)});
    endtask

    task automatic set_in(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                          input logic r1, input logic [4:0] a1,
                          input logic r2, input logic [4:0] a2);
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
    endtask

    // Counts edges from now until busy drops; expects exactly 32.
    task automatic wait_ready(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            edge_update();
            n++;
        end
        check(name, 32'(n), 32'd32);
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 1; i < 32; i++) begin
            set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(32 - i));
            settle();
            check({name, "_p1"}, rdata1, 32'h0);
            check({name, "_p2"}, rdata2, 32'h0);
            edge_update();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd4);
`ifdef REGFILE_DBG_PORT_EN
        dbg_addr = 5'd0;
`endif
        repeat (3) edge_update();
        settle();
        check("reset_busy", {31'b0, busy}, 32'd1);
        check("reset_rd1", rdata1, 32'h0);
        check("reset_rd2", rdata2, 32'h0);

        rst = 1'b1;
        settle();
        check_model("release");
        wait_ready("clear_len");
        check_all_zero("post_clear");

        //               we    wa     wd            re1   ra1    re2   ra2    e1            e2
        vecs[0]  = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd5,  1'b0, 5'd5,  32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd5,  32'h12345678, 32'h0};
        vecs[2]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b1, 5'd7,  1'b1, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd5,  32'h0,        32'h12345678};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd7,  32'h0,        32'hDEADBEEF};
        vecs[6]  = '{1'b1, 5'd5,  32'hCAFEF00D, 1'b1, 5'd5,  1'b1, 5'd5,  32'hCAFEF00D, 32'hCAFEF00D};
        vecs[7]  = '{1'b1, 5'd9,  32'hA5A5A5A5, 1'b1, 5'd5,  1'b1, 5'd9,  32'hCAFEF00D, 32'hA5A5A5A5};
        vecs[8]  = '{1'b0, 5'd9,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  32'hA5A5A5A5, 32'h0};
        vecs[9]  = '{1'b1, 5'd31, 32'h80000001, 1'b1, 5'd31, 1'b1, 5'd1,  32'h80000001, 32'h0};
        vecs[10] = '{1'b0, 5'd31, 32'h0,        1'b1, 5'd31, 1'b1, 5'd30, 32'h80000001, 32'h0};

        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i].we, vecs[i].wa, vecs[i].wd,
                   vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
            settle();
            check($sformatf("vec%0d_rd1", i), rdata1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), rdata2, vecs[i].e2);
            check($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd0);
            edge_update();
        end

`ifdef REGFILE_DBG_PORT_EN
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        dbg_addr = 5'd0;
        settle();
        check("dbg_zero", dbg_data, 32'h0);
        dbg_addr = 5'd7;
        #1;
        check("dbg_r7", dbg_data, 32'hDEADBEEF);
        edge_update();
`endif

        // Reset pulse during READY; r9 currently holds A5A5A5A5.
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
        rst = 1'b0;
        settle();
        check("rstlow_rd1", rdata1, 32'h0);
        check("rstlow_busy_pre", {31'b0, busy}, 32'd0);
        edge_update();
        check("rstlow_busy_post", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        set_in(1'b1, 5'd10, 32'h1, 1'b1, 5'd10, 1'b1, 5'd9);
        settle();
        check("clear_wr_rd1", rdata1, 32'h0);
        wait_ready("midop_clear_len");
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd10);
        settle();
        check("midop_r9", rdata1, 32'h0);
        check("midop_r10", rdata2, 32'h0);
        edge_update();

        // Reset re-asserted part way through CLEAR restarts the full sequence.
        rst = 1'b0;
        edge_update();
        rst = 1'b1;
        repeat (11) edge_update();
        rst = 1'b0;
        edge_update();
        rst = 1'b1;
        wait_ready("reclear_len");
        check_all_zero("reclear");

        // Randomized traffic with occasional resets, checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) != 0);
            we    = $urandom_range(0, 1) == 1;
            waddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                : 5'($urandom_range(0, 7));
            wdata = $urandom;
            re1   = $urandom_range(0, 3) != 0;
            re2   = $urandom_range(0, 3) != 0;
            raddr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 7));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 7));
            settle();
            check_model("rand");
            edge_update();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
